// File: rtl/sargantana_icache_tag_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sargantana_icache_tag_pkg
//  Purpose  : Shared types and default sizes for the instruction-cache tag
//             lookup/refill sequencer.
//  Contents : tag_ctrl_state_t - sequencer state encoding
//             C_DEFAULT_WAYS, C_DEFAULT_TAG_WIDTH - default geometry
//  Revision : 1.0 - initial release
// ============================================================================
package sargantana_icache_tag_pkg;

    localparam int unsigned C_DEFAULT_WAYS      = 4;
    localparam int unsigned C_DEFAULT_TAG_WIDTH = 20;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        MISS_WAIT = 3'd2,
        REFILL_WR = 3'd3,
        DRAIN     = 3'd4
    } tag_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/sargantana_icache_victim_sel.sv
`default_nettype none
// ============================================================================
//  Module   : sargantana_icache_victim_sel
//  Purpose  : Combinational replacement-way chooser. Prefers the lowest-index
//             invalid way; when every way is valid it falls back to the
//             round-robin pointer and flags that it did so.
//  Ports    : i_valid   - valid bit of each way for the looked-up set
//             i_rr_ptr  - current round-robin pointer
//             o_victim  - selected way index
//             o_used_rr - 1 when o_victim came from i_rr_ptr
//  Revision : 1.0 - initial release
// ============================================================================
module sargantana_icache_victim_sel
    import sargantana_icache_tag_pkg::*;
#(
    parameter int unsigned WAYS          = C_DEFAULT_WAYS,
    parameter int unsigned WAY_IDX_WIDTH = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]          i_valid,
    input  logic [WAY_IDX_WIDTH-1:0] i_rr_ptr,
    output logic [WAY_IDX_WIDTH-1:0] o_victim,
    output logic                     o_used_rr
);

    // Scan from the top down so the last assignment is the lowest invalid way.
    always_comb begin
        o_victim  = i_rr_ptr;
        o_used_rr = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!i_valid[w]) begin
                o_victim  = WAY_IDX_WIDTH'(w);
                o_used_rr = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sargantana_icache_tag_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sargantana_icache_tag_ctrl
//  Purpose  : Lookup/refill sequencer in front of the instruction-cache tag
//             ways. Reads all ways on a lookup, compares one cycle later,
//             reports hit/miss, and on a miss writes the refilled tag into a
//             victim way. Forwards flushes and drops refills orphaned by one.
//  Ports    : clk_i, rst_i          - clock, synchronous active-high reset
//             flush_i               - invalidate the whole cache
//             lookup_*              - lookup request handshake (idx, tag)
//             rsp_*                 - one-cycle lookup result (hit, way)
//             miss_req_o            - one-cycle refill request
//             refill_valid_i        - refill for the outstanding miss arrived
//             refill_done_o         - one-cycle pulse on the tag write
//             way_*_o               - tag-way request/write/flush interface
//             way_tag_i, way_vbit_i - registered read data from the ways
//  Revision : 1.0 - initial release
// ============================================================================
module sargantana_icache_tag_ctrl
    import sargantana_icache_tag_pkg::*;
#(
    parameter int unsigned WAYS           = C_DEFAULT_WAYS,
    parameter int unsigned TAG_DEPTH      = 64,
    parameter int unsigned TAG_ADDR_WIDTH = $clog2(TAG_DEPTH),
    parameter int unsigned TAG_WIDTH      = C_DEFAULT_TAG_WIDTH,
    parameter int unsigned WAY_IDX_WIDTH  = $clog2(WAYS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      lookup_valid_i,
    output logic                      lookup_ready_o,
    input  logic [TAG_ADDR_WIDTH-1:0] lookup_idx_i,
    input  logic [TAG_WIDTH-1:0]      lookup_tag_i,
    output logic                      rsp_valid_o,
    output logic                      rsp_hit_o,
    output logic [WAY_IDX_WIDTH-1:0]  rsp_way_o,
    output logic                      miss_req_o,
    input  logic                      refill_valid_i,
    output logic                      refill_done_o,
    output logic [WAYS-1:0]           way_req_o,
    output logic [WAYS-1:0]           way_we_o,
    output logic [TAG_ADDR_WIDTH-1:0] way_addr_o,
    output logic [TAG_WIDTH-1:0]      way_data_o,
    output logic                      way_vbit_o,
    output logic [WAYS-1:0]           way_flush_o,
    input  logic [WAYS*TAG_WIDTH-1:0] way_tag_i,
    input  logic [WAYS-1:0]           way_vbit_i
);

    tag_ctrl_state_t            r_state;
    tag_ctrl_state_t            w_state_next;
    logic [TAG_ADDR_WIDTH-1:0]  r_idx;
    logic [TAG_WIDTH-1:0]       r_tag;
    logic [WAY_IDX_WIDTH-1:0]   r_victim;
    logic                       r_used_rr;
    logic [WAY_IDX_WIDTH-1:0]   r_rr_ptr;

    logic [WAYS-1:0]            w_hit;
    logic [WAY_IDX_WIDTH-1:0]   w_hit_way;
    logic [WAY_IDX_WIDTH-1:0]   w_victim;
    logic                       w_used_rr;
    logic [WAYS-1:0]            w_victim_onehot;
    logic                       w_accept;
    logic                       w_latch_victim;
    logic                       w_rr_adv;

    // Flush reaches the ways unconditionally, including during reset.
    assign way_flush_o = {WAYS{flush_i}};
    assign way_vbit_o  = 1'b1;

    for (genvar w = 0; w < WAYS; w++) begin : g_hit
        assign w_hit[w] = way_vbit_i[w] &
                          (way_tag_i[w*TAG_WIDTH +: TAG_WIDTH] == r_tag);
    end

    // Lowest matching way wins.
    always_comb begin
        w_hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_hit[w]) begin
                w_hit_way = WAY_IDX_WIDTH'(w);
            end
        end
    end

    sargantana_icache_victim_sel #(
        .WAYS          (WAYS),
        .WAY_IDX_WIDTH (WAY_IDX_WIDTH)
    ) u_victim_sel (
        .i_valid   (way_vbit_i),
        .i_rr_ptr  (r_rr_ptr),
        .o_victim  (w_victim),
        .o_used_rr (w_used_rr)
    );

    assign w_victim_onehot = {{(WAYS-1){1'b0}}, 1'b1} << r_victim;

    always_comb begin
        w_state_next   = r_state;
        lookup_ready_o = 1'b0;
        rsp_valid_o    = 1'b0;
        rsp_hit_o      = 1'b0;
        rsp_way_o      = '0;
        miss_req_o     = 1'b0;
        refill_done_o  = 1'b0;
        way_req_o      = '0;
        way_we_o       = '0;
        way_addr_o     = '0;
        way_data_o     = '0;
        w_accept       = 1'b0;
        w_latch_victim = 1'b0;
        w_rr_adv       = 1'b0;

        case (r_state)
            IDLE: begin
                lookup_ready_o = !flush_i;
                if (lookup_valid_i && !flush_i) begin
                    w_accept     = 1'b1;
                    way_req_o    = '1;
                    way_addr_o   = lookup_idx_i;
                    w_state_next = COMPARE;
                end
            end
            COMPARE: begin
                // A flush makes the read data stale, so the result is dropped.
                w_state_next = IDLE;
                if (!flush_i) begin
                    rsp_valid_o = 1'b1;
                    rsp_hit_o   = |w_hit;
                    rsp_way_o   = w_hit_way;
                    if (!(|w_hit)) begin
                        miss_req_o     = 1'b1;
                        w_latch_victim = 1'b1;
                        w_state_next   = MISS_WAIT;
                    end
                end
            end
            MISS_WAIT: begin
                // A refill coinciding with the flush is consumed here, so
                // there is nothing left to drain.
                if (flush_i) begin
                    w_state_next = refill_valid_i ? IDLE : DRAIN;
                end else if (refill_valid_i) begin
                    w_state_next = REFILL_WR;
                end
            end
            REFILL_WR: begin
                w_state_next = IDLE;
                if (!flush_i) begin
                    way_req_o     = w_victim_onehot;
                    way_we_o      = w_victim_onehot;
                    way_addr_o    = r_idx;
                    way_data_o    = r_tag;
                    refill_done_o = 1'b1;
                    w_rr_adv      = r_used_rr;
                end
            end
            DRAIN: begin
                if (refill_valid_i && !flush_i) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_tag     <= '0;
            r_victim  <= '0;
            r_used_rr <= 1'b0;
            r_rr_ptr  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_idx <= lookup_idx_i;
                r_tag <= lookup_tag_i;
            end
            if (w_latch_victim) begin
                r_victim  <= w_victim;
                r_used_rr <= w_used_rr;
            end
            if (w_rr_adv) begin
                r_rr_ptr <= r_rr_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sargantana_icache_tag_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sargantana_icache_tag_ctrl
//  Purpose  : Self-checking bench for sargantana_icache_tag_ctrl with a
//             behavioural model of the tag-way memories and a scoreboard of
//             hand-computed lookup results and refill writes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sargantana_icache_tag_ctrl;

    localparam int WAYS  = 4;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int TW    = 20;
    localparam int WW    = 2;

    typedef struct packed {
        logic          hit;
        logic [WW-1:0] way;
        logic          miss;
    } rsp_exp_t;

    typedef struct packed {
        logic [WAYS-1:0] we;
        logic [AW-1:0]   addr;
        logic [TW-1:0]   data;
    } wr_exp_t;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              lk_valid;
    logic              lk_ready;
    logic [AW-1:0]     lk_idx;
    logic [TW-1:0]     lk_tag;
    logic              rsp_valid;
    logic              rsp_hit;
    logic [WW-1:0]     rsp_way;
    logic              miss_req;
    logic              refill;
    logic              refill_done;
    logic [WAYS-1:0]   way_req;
    logic [WAYS-1:0]   way_we;
    logic [AW-1:0]     way_addr;
    logic [TW-1:0]     way_data;
    logic              way_vbit;
    logic [WAYS-1:0]   way_flush;
    logic [WAYS*TW-1:0] way_tag;
    logic [WAYS-1:0]   rd_v;
    logic [TW-1:0]     rd_tag [WAYS];

    logic [TW-1:0]     mem_tag [WAYS][DEPTH];
    logic              mem_v   [WAYS][DEPTH];

    logic              poke_en;
    logic [WW-1:0]     poke_way;
    logic [AW-1:0]     poke_idx;
    logic [TW-1:0]     poke_tag;
    logic              poke_v;

    rsp_exp_t rsp_q [$];
    wr_exp_t  wr_q  [$];
    int n_checks = 0;
    int n_fail   = 0;

    sargantana_icache_tag_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .lookup_valid_i (lk_valid),
        .lookup_ready_o (lk_ready),
        .lookup_idx_i   (lk_idx),
        .lookup_tag_i   (lk_tag),
        .rsp_valid_o    (rsp_valid),
        .rsp_hit_o      (rsp_hit),
        .rsp_way_o      (rsp_way),
        .miss_req_o     (miss_req),
        .refill_valid_i (refill),
        .refill_done_o  (refill_done),
        .way_req_o      (way_req),
        .way_we_o       (way_we),
        .way_addr_o     (way_addr),
        .way_data_o     (way_data),
        .way_vbit_o     (way_vbit),
        .way_flush_o    (way_flush),
        .way_tag_i      (way_tag),
        .way_vbit_i     (rd_v)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tag-way memory model: one-cycle registered read, single-cycle flush.
    always @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (rst) begin
                for (int d = 0; d < DEPTH; d++) begin
                    mem_v[w][d]   <= 1'b0;
                    mem_tag[w][d] <= '0;
                end
            end else if (way_flush[w]) begin
                for (int d = 0; d < DEPTH; d++) mem_v[w][d] <= 1'b0;
            end else if (way_req[w] && way_we[w]) begin
                mem_tag[w][way_addr] <= way_data;
                mem_v[w][way_addr]   <= way_vbit;
            end
            if (way_req[w]) begin
                rd_tag[w] <= mem_tag[w][way_addr];
                rd_v[w]   <= mem_v[w][way_addr];
            end
        end
        if (poke_en && !rst) begin
            mem_tag[poke_way][poke_idx] <= poke_tag;
            mem_v[poke_way][poke_idx]   <= poke_v;
        end
    end

    always_comb begin
        way_tag = '0;
        for (int w = 0; w < WAYS; w++) way_tag[w*TW +: TW] = rd_tag[w];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result/write.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rsp_valid) begin
                    n_checks++;
                    if (rsp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL rsp_unexpected: got rsp hit=%0d required none at %0t", rsp_hit, $time);
                    end else begin
                        rsp_exp_t e;
                        e = rsp_q.pop_front();
                        chk("rsp_hit", rsp_hit, e.hit);
                        if (e.hit) chk("rsp_way", rsp_way, e.way);
                        chk("rsp_miss_req", miss_req, e.miss);
                    end
                end else begin
                    chk("miss_req_alone", miss_req, 0);
                end
                if (way_we != 0 || refill_done) begin
                    n_checks++;
                    if (wr_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL wr_unexpected: got we=0x%0h done=%0d required none at %0t", way_we, refill_done, $time);
                    end else begin
                        wr_exp_t e;
                        e = wr_q.pop_front();
                        chk("wr_we",   way_we, e.we);
                        chk("wr_req",  way_req, e.we);
                        chk("wr_addr", way_addr, e.addr);
                        chk("wr_data", way_data, e.data);
                        chk("wr_vbit", way_vbit, 1);
                        chk("wr_done", refill_done, 1);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_lookup(input logic [AW-1:0] idx, input logic [TW-1:0] tag,
                             input logic hit, input logic [WW-1:0] way);
        rsp_q.push_back('{hit: hit, way: way, miss: !hit});
        lk_valid = 1'b1;
        lk_idx   = idx;
        lk_tag   = tag;
        @(negedge clk);
        chk("lookup_ready", lk_ready, 1);
        chk("lookup_req", way_req, 4'hf);
        chk("lookup_addr", way_addr, idx);
        @(posedge clk); #1;
        lk_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_refill(input logic [WAYS-1:0] we, input logic [AW-1:0] idx, input logic [TW-1:0] tag);
        wr_q.push_back('{we: we, addr: idx, data: tag});
        refill = 1'b1;
        @(posedge clk); #1;
        refill = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_miss(input logic [AW-1:0] idx, input logic [TW-1:0] tag, input logic [WAYS-1:0] we);
        do_lookup(idx, tag, 1'b0, '0);
        do_refill(we, idx, tag);
    endtask

    task automatic do_poke(input logic [WW-1:0] w, input logic [AW-1:0] idx,
                           input logic [TW-1:0] tag, input logic v);
        poke_en = 1'b1; poke_way = w; poke_idx = idx; poke_tag = tag; poke_v = v;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    initial begin
        logic [WAYS-1:0] rr_we [5];
        rr_we[0] = 4'b0001; rr_we[1] = 4'b0010; rr_we[2] = 4'b0100;
        rr_we[3] = 4'b1000; rr_we[4] = 4'b0001;

        rst = 1'b1; flush = 1'b0; lk_valid = 1'b0; lk_idx = '0; lk_tag = '0;
        refill = 1'b0; poke_en = 1'b0; poke_way = '0; poke_idx = '0;
        poke_tag = '0; poke_v = 1'b0;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_ready", lk_ready, 1);
        chk("rst_vbit", way_vbit, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_way_req", way_req, 0);
        chk("rst_way_we", way_we, 0);
        chk("rst_refill_done", refill_done, 0);
        chk("rst_way_flush", way_flush, 0);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("rst_flush_fwd", way_flush, 4'hf);
        @(posedge clk); #1;
        flush = 1'b0;
        rst   = 1'b0;

        // Cold miss then hit
        do_miss(6'd5, 20'hABCDE, 4'b0001);
        do_lookup(6'd5, 20'hABCDE, 1'b1, 2'd0);

        // Fill remaining ways of set 5 (lowest invalid way first)
        do_miss(6'd5, 20'h11111, 4'b0010);
        do_miss(6'd5, 20'h22222, 4'b0100);
        do_miss(6'd5, 20'h33333, 4'b1000);
        do_lookup(6'd5, 20'h22222, 1'b1, 2'd2);

        // Full set: round-robin victims 0,1,2,3,0 then 1 (pointer wrapped)
        for (int i = 0; i < 5; i++) do_miss(6'd5, 20'h40000 + i, rr_we[i]);
        do_miss(6'd5, 20'h50000, 4'b0010);
        do_lookup(6'd5, 20'h40004, 1'b1, 2'd0);
        do_lookup(6'd5, 20'h50000, 1'b1, 2'd1);
        do_lookup(6'd5, 20'h40003, 1'b1, 2'd3);

        // Priority: invalid way1 ignored, ways 2 and 3 match -> way 2
        do_poke(2'd1, 6'd9, 20'h0BEEF, 1'b0);
        do_poke(2'd2, 6'd9, 20'h0BEEF, 1'b1);
        do_poke(2'd3, 6'd9, 20'h0BEEF, 1'b1);
        do_lookup(6'd9, 20'h0BEEF, 1'b1, 2'd2);

        // Flush during MISS_WAIT -> DRAIN, late refill discarded
        do_lookup(6'd5, 20'h60000, 1'b0, '0);
        flush = 1'b1;
        @(negedge clk);
        chk("mw_flush_fwd", way_flush, 4'hf);
        chk("mw_ready", lk_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("mw_flush_pulse", way_flush, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("drain_ready", lk_ready, 0);
        end
        @(posedge clk); #1;
        refill = 1'b1;
        @(posedge clk); #1;
        refill = 1'b0;
        @(negedge clk);
        chk("drain_exit_ready", lk_ready, 1);
        chk("drain_no_write", way_we, 0);
        @(posedge clk); #1;
        do_miss(6'd5, 20'h40004, 4'b0001);

        // Flush during REFILL_WR: write suppressed, pointer unchanged
        do_lookup(6'd5, 20'h40001, 1'b0, '0);
        refill = 1'b1;
        @(posedge clk); #1;
        refill = 1'b0;
        flush  = 1'b1;
        @(negedge clk);
        chk("rw_flush_we", way_we, 0);
        chk("rw_flush_done", refill_done, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 4; i++) do_miss(6'd20, 20'h00001 + i, rr_we[i]);
        do_miss(6'd20, 20'h00005, 4'b0100);

        // Flush held with a lookup pending in IDLE
        flush = 1'b1; lk_valid = 1'b1; lk_idx = 6'd3; lk_tag = 20'h12345;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("idle_flush_ready", lk_ready, 0);
            chk("idle_flush_req", way_req, 0);
            chk("idle_flush_fwd", way_flush, 4'hf);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        rsp_q.push_back('{hit: 1'b0, way: '0, miss: 1'b1});
        @(negedge clk);
        chk("post_flush_ready", lk_ready, 1);
        chk("post_flush_req", way_req, 4'hf);
        chk("post_flush_addr", way_addr, 3);
        @(posedge clk); #1;
        lk_valid = 1'b0;
        @(posedge clk); #1;
        do_refill(4'b0001, 6'd3, 20'h12345);

        // Flush in COMPARE suppresses the response
        lk_valid = 1'b1; lk_idx = 6'd3; lk_tag = 20'h12345;
        @(posedge clk); #1;
        lk_valid = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        chk("cmp_flush_rsp", rsp_valid, 0);
        chk("cmp_flush_miss", miss_req, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("cmp_flush_idle", lk_ready, 1);
        @(posedge clk); #1;

        // Stray refill in IDLE is ignored
        refill = 1'b1;
        @(posedge clk); #1;
        refill = 1'b0;
        @(negedge clk);
        chk("stray_refill_we", way_we, 0);
        chk("stray_refill_ready", lk_ready, 1);
        @(posedge clk); #1;
        do_lookup(6'd3, 20'h12345, 1'b0, '0);
        do_refill(4'b0001, 6'd3, 20'h12345);
        do_lookup(6'd3, 20'h12345, 1'b1, 2'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("rsp_q_empty", rsp_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sargantana_icache_tag_ctrl.md
Name: sargantana_icache_tag_ctrl

Overview:
- Lookup/refill sequencer that sits directly in front of the WAYS instruction-cache tag-way memories and drives their req/we/addr/data/vbit/flush inputs.
- On a lookup it reads all ways, compares the registered tag and valid bit of every way one cycle later, and reports hit/miss with the hit way.
- On a miss it waits for the refill response, selects a victim way and writes the new tag with valid=1.
- It also forwards cache flushes and discards refills orphaned by a flush.

Parameters:
- WAYS, 4, number of tag ways (power of two, ≥2).
- TAG_DEPTH, 64, sets per way.
- TAG_ADDR_WIDTH, $clog2(TAG_DEPTH), set index width.
- TAG_WIDTH, 20, tag width.
- WAY_IDX_WIDTH, $clog2(WAYS), encoded way width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  invalidate entire cache
- lookup_valid_i  in  1  lookup request
- lookup_ready_o  out  1  lookup accepted when valid&ready
- lookup_idx_i  in  TAG_ADDR_WIDTH  set index
- lookup_tag_i  in  TAG_WIDTH  tag to compare
- rsp_valid_o  out  1  one-cycle lookup result strobe
- rsp_hit_o  out  1  hit flag, qualified by rsp_valid_o
- rsp_way_o  out  WAY_IDX_WIDTH  hit way; lowest matching index wins
- miss_req_o  out  1  one-cycle pulse requesting a line refill
- refill_valid_i  in  1  one-cycle pulse: refill for the outstanding miss has arrived
- refill_done_o  out  1  one-cycle pulse on the tag write
- way_req_o  out  WAYS  per-way request
- way_we_o  out  WAYS  per-way write enable
- way_addr_o  out  TAG_ADDR_WIDTH  shared set index
- way_data_o  out  TAG_WIDTH  shared write tag
- way_vbit_o  out  1  write valid bit, constant 1
- way_flush_o  out  WAYS  per-way flush
- way_tag_i  in  WAYS*TAG_WIDTH  read tags; way w occupies bits [w*TAG_WIDTH +: TAG_WIDTH]
- way_vbit_i  in  WAYS  read valid bits

Behaviour:
- Tag ways have one-cycle registered read latency. Their flush clears all valid bits in one cycle.
- States:
  - IDLE: lookup_ready_o=1 unless flush_i. On accept, drive way_req_o='1, way_we_o='0, way_addr_o=lookup_idx_i; register idx and tag; go to COMPARE.
  - COMPARE: hit[w]=way_vbit_i[w] & (way_tag_i[w]==tag_q). Assert rsp_valid_o and rsp_hit_o=|hit; rsp_way_o is the priority-encoded hit vector.
    - On a hit, go to IDLE.
    - On a miss, pulse miss_req_o, latch victim (the lowest-index invalid way, else rr_ptr), go to MISS_WAIT.
  - MISS_WAIT: lookup_ready_o=0. When refill_valid_i, go to REFILL_WR.
  - REFILL_WR: drive way_req_o=way_we_o=onehot(victim), way_addr_o=idx_q, way_data_o=tag_q, way_vbit_o=1. Pulse refill_done_o. If the victim came from rr_ptr, increment rr_ptr (mod WAYS). Go to IDLE.
  - DRAIN: lookup_ready_o=0. When refill_valid_i, go to IDLE with no write.
- No back-to-back lookups: at most one lookup is accepted every 2 cycles (IDLE→COMPARE→IDLE).
- Flush:
  - way_flush_o={WAYS{flush_i}}, combinational, in every state.
  - In IDLE: lookup is not accepted.
  - In COMPARE: the response is suppressed (rsp_valid_o=0, no miss_req_o), go to IDLE.
  - In MISS_WAIT: go to DRAIN, or to IDLE if refill_valid_i is in the same cycle.
  - In REFILL_WR: the write is suppressed, go to IDLE, rr_ptr unchanged.
  - In DRAIN: stay in DRAIN.
- refill_valid_i outside MISS_WAIT/DRAIN is ignored.
- Reset:
  - State=IDLE, rr_ptr=0, idx_q/tag_q/victim_q=0.
  - All outputs 0 except lookup_ready_o=1 and way_vbit_o=1.
  - way_flush_o follows flush_i, so a flush asserted during reset still reaches the ways.
  - Reset mid-miss abandons the refill without a drain; the upstream fill path is reset together with this block.
- All strobes are exactly one cycle.

Decomposition:
- Package sargantana_icache_tag_pkg:
  - state enum tag_ctrl_state_t {IDLE, COMPARE, MISS_WAIT, REFILL_WR, DRAIN}
  - default WAYS/TAG_WIDTH constants
- One sub-module, sargantana_icache_victim_sel: takes the valid vector and rr_ptr and returns the victim index plus a used_rr flag. It is purely combinational.
- rr_ptr is registered in the parent.

Test Plan:
- Reset, then lookup idx=5 tag=0xABCDE on an empty cache → cycle+1: rsp_valid=1, hit=0, miss_req=1; refill_valid → next cycle way_we_o=4'b0001, addr=5, data=0xABCDE, refill_done=1.
- Repeat the same lookup → cycle+1: rsp_valid=1, hit=1, way=0, no miss_req.
- Fill set 5 in all 4 ways, then miss 5 more times on set 5 → victims are ways 0,1,2,3,0 in turn; rr_ptr wraps to 1.
- Flush in MISS_WAIT → way_flush_o=4'b1111 for 1 cycle, state DRAIN; refill_valid 3 cycles later → no write, lookup_ready=1 next cycle; earlier hit tag now misses.
- flush_i held high concurrently with lookup_valid_i in IDLE → lookup_ready=0, no way_req_o; lookup accepted on the cycle after flush drops.
